adc8_reader: RTL and testbench



---
 rtl/adc_hub_pkg.sv | 8 +
 rtl/sync_fifo.sv | 57 +++++
 rtl/adc8_reader.sv | 110 +++++++++++
 tb/tb_adc8_reader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_hub_pkg.sv
// Definitions shared by the sensor-hub ADC channels: sample width, sample type
// and the default converter-stall timeout.
package adc_hub_pkg;
    localparam int ADC_W = 8;
    typedef logic [ADC_W-1:0] adc_sample_t;
    // 2 ms at 50 MHz
    localparam int TIMEOUT_CYCLES_DEFAULT = 100000;
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: circular buffer with wrapping pointers and an
// occupancy count. Reused by other hub channels.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(DEPTH));
    assign rdata = mem[rd_ptr];

    // A pop frees the head slot first, so a push into a full FIFO is accepted
    // when it coincides with a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/adc8_reader.sv
// Consumer end of the 8-bit ADC busy/dout interface: captures a sample on each
// busy falling edge, box-car averages, and queues results in a show-ahead FIFO.
module adc8_reader
    import adc_hub_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int AVG_LOG2       = 0,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic                     adc_busy,
    input  logic [ADC_W-1:0]         adc_dout,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [ADC_W-1:0]         m_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     timeout,
    input  logic                     clr_flags
);
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_PRE  = TMO_W'(TIMEOUT_CYCLES - 1);

    logic              busy_q;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic [TMO_W-1:0]  tmo_cnt;

    logic              sample_evt;
    logic [ACC_W-1:0]  sum;
    logic              push;
    adc_sample_t       push_data;
    logic              pop;
    logic              full;
    logic              empty;
    logic              drop;
    logic              tmo_hit;

    assign sample_evt = ena & busy_q & ~adc_busy;
    assign sum        = acc + ACC_W'(adc_dout);
    assign push       = sample_evt & (cnt == CNT_LAST);
    assign push_data  = ADC_W'(sum >> AVG_LOG2);

    // Output stream: a word transfers on any cycle where m_valid and m_ready are
    // both high; m_valid never drops until its word transfers, m_ready is free.
    assign m_valid = ~empty;
    assign pop     = m_valid & m_ready;
    assign drop    = push & full & ~pop;
    // Raised only on the step into saturation, so a cleared flag stays clear
    // until an event re-arms the counter.
    assign tmo_hit = ena & ~sample_evt & (tmo_cnt == TMO_PRE);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADC_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (push_data),
        .rdata (m_data),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            tmo_cnt  <= '0;
            overflow <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            busy_q <= adc_busy;
            if (sample_evt) begin
                if (push) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                end
            end
            if (sample_evt) begin
                tmo_cnt <= '0;
            end else if (ena && tmo_cnt != TMO_MAX) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
            if (tmo_hit) begin
                timeout <= 1'b1;
            end else if (clr_flags) begin
                timeout <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adc8_reader.sv
// Bench for adc8_reader: two instances (pass-through and 4-sample average) on a
// shared stimulus, checked each cycle against a sample-list reference model.
module tb_adc8_reader;
    localparam int DEPTH = 4;
    localparam int TMO   = 20;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic          adc_busy;
    logic [7:0]    adc_dout;
    logic          m_ready;
    logic          clr_flags;

    logic          valid0, valid1;
    logic [7:0]    data0, data1;
    logic [LW-1:0] level0, level1;
    logic          ovf0, ovf1;
    logic          tmo0, tmo1;

    always #5 clk = ~clk;

    adc8_reader #(.DEPTH(DEPTH), .AVG_LOG2(0), .TIMEOUT_CYCLES(TMO)) dut0 (
        .clk(clk), .rst(rst), .ena(ena), .adc_busy(adc_busy), .adc_dout(adc_dout),
        .m_valid(valid0), .m_ready(m_ready), .m_data(data0), .level(level0),
        .overflow(ovf0), .timeout(tmo0), .clr_flags(clr_flags)
    );

    adc8_reader #(.DEPTH(DEPTH), .AVG_LOG2(2), .TIMEOUT_CYCLES(TMO)) dut1 (
        .clk(clk), .rst(rst), .ena(ena), .adc_busy(adc_busy), .adc_dout(adc_dout),
        .m_valid(valid1), .m_ready(m_ready), .m_data(data1), .level(level1),
        .overflow(ovf1), .timeout(tmo1), .clr_flags(clr_flags)
    );

    // Reference model: expected FIFO contents, running sample sum/count,
    // sticky flags and idle-cycle count per instance.
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int         acc_sum [2];
    int         acc_n   [2];
    int         idle    [2];
    bit         m_ovf   [2];
    bit         m_tmo   [2];
    bit         prev_busy;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int q_size(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [7:0] q_front(input int d);
        return (d == 0) ? exp_q0[0] : exp_q1[0];
    endfunction

    task automatic model_update();
        bit ev;
        if (rst) begin
            exp_q0 = {};
            exp_q1 = {};
            for (int d = 0; d < 2; d++) begin
                acc_sum[d] = 0; acc_n[d] = 0; idle[d] = 0; m_ovf[d] = 0; m_tmo[d] = 0;
            end
            prev_busy = 0;
            return;
        end
        ev = ena && prev_busy && !adc_busy;
        for (int d = 0; d < 2; d++) begin
            int n_avg;
            int val;
            bit pop;
            bit push;
            bit was_full;
            n_avg    = (d == 0) ? 1 : 4;
            pop      = (q_size(d) > 0) && m_ready;
            was_full = (q_size(d) == DEPTH);
            push     = 0;
            val      = 0;
            if (ev) begin
                acc_sum[d] += int'(adc_dout);
                acc_n[d]++;
                if (acc_n[d] == n_avg) begin
                    push = 1;
                    val = acc_sum[d] / n_avg;
                    acc_sum[d] = 0;
                    acc_n[d] = 0;
                end
            end
            if (pop) begin
                if (d == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
            end
            if (clr_flags) begin
                m_ovf[d] = 0;
                m_tmo[d] = 0;
            end
            if (push) begin
                if (was_full && !pop) m_ovf[d] = 1;
                else if (d == 0) exp_q0.push_back(8'(val));
                else exp_q1.push_back(8'(val));
            end
            if (ev) idle[d] = 0;
            else if (ena && idle[d] < TMO) begin
                idle[d]++;
                if (idle[d] == TMO) m_tmo[d] = 1;
            end
        end
        prev_busy = adc_busy;
    endtask

    task automatic compare_all();
        check("valid0", 32'(valid0), 32'(q_size(0) != 0));
        check("level0", 32'(level0), 32'(q_size(0)));
        if (q_size(0) != 0) check("data0", 32'(data0), 32'(q_front(0)));
        check("ovf0", 32'(ovf0), 32'(m_ovf[0]));
        check("tmo0", 32'(tmo0), 32'(m_tmo[0]));
        check("valid1", 32'(valid1), 32'(q_size(1) != 0));
        check("level1", 32'(level1), 32'(q_size(1)));
        if (q_size(1) != 0) check("data1", 32'(data1), 32'(q_front(1)));
        check("ovf1", 32'(ovf1), 32'(m_ovf[1]));
        check("tmo1", 32'(tmo1), 32'(m_tmo[1]));
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic cyc(input logic busy, input logic [7:0] dout);
        adc_busy = busy;
        adc_dout = dout;
        tick();
    endtask

    task automatic conv(input logic [7:0] sample);
        cyc(1'b1, 8'($urandom_range(0, 255)));
        cyc(1'b0, sample);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] s [4];
        int sum4;
        rst = 1'b1; ena = 1'b1; adc_busy = 1'b0; adc_dout = 8'h00;
        m_ready = 1'b0; clr_flags = 1'b0;

        // Reset state
        do_reset();
        check("rst_valid", 32'(valid0), 32'd0);
        check("rst_level", 32'(level0), 32'd0);
        check("rst_data", 32'(data0), 32'd0);
        check("rst_flags", 32'({ovf0, tmo0, ovf1, tmo1}), 32'd0);

        // Single conversion after a long busy phase
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'h00);
        cyc(1'b0, 8'h2A);
        check("tp1_valid", 32'(valid0), 32'd1);
        check("tp1_data", 32'(data0), 32'h2A);
        check("tp1_level", 32'(level0), 32'd1);

        // Four-sample average: nothing until the 4th event, then 101>>2
        do_reset();
        conv(8'd10); conv(8'd20); conv(8'd30);
        check("avg_nopush", 32'(level1), 32'd0);
        conv(8'd41);
        check("avg_level", 32'(level1), 32'd1);
        check("avg_data", 32'(data1), 32'd25);

        // Overflow on the 5th push, then drain in order
        do_reset();
        for (int i = 1; i <= 5; i++) conv(8'(i));
        check("ovf_level", 32'(level0), 32'd4);
        check("ovf_flag", 32'(ovf0), 32'd1);
        adc_busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_data", 32'(data0), 32'(i));
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
        end
        check("drain_empty", 32'(valid0), 32'd0);

        // Full FIFO, push and pop in the same cycle
        do_reset();
        for (int i = 0; i < 4; i++) conv(8'($urandom_range(0, 255)));
        cyc(1'b1, 8'h00);
        m_ready = 1'b1;
        cyc(1'b0, 8'hC3);
        m_ready = 1'b0;
        check("pp_level", 32'(level0), 32'd4);
        check("pp_ovf", 32'(ovf0), 32'd0);

        // Timeout after TMO idle enabled cycles, clear, re-arm
        do_reset();
        for (int i = 0; i < TMO - 1; i++) cyc(1'b1, 8'h00);
        check("tmo_early", 32'(tmo0), 32'd0);
        cyc(1'b1, 8'h00);
        check("tmo_hit", 32'(tmo0), 32'd1);
        clr_flags = 1'b1;
        cyc(1'b1, 8'h00);
        clr_flags = 1'b0;
        check("tmo_clr", 32'(tmo0), 32'd0);
        for (int i = 0; i < 30; i++) cyc(1'b1, 8'h00);
        check("tmo_stay_clr", 32'(tmo0), 32'd0);
        conv(8'h11);
        for (int i = 0; i < TMO - 1; i++) cyc(1'b1, 8'h00);
        check("tmo_rearm_early", 32'(tmo0), 32'd0);
        cyc(1'b1, 8'h00);
        check("tmo_rearm", 32'(tmo0), 32'd1);

        // ena=0 blocks events; reset mid-average discards the partial sum
        do_reset();
        m_ready = 1'b0;
        conv(8'($urandom_range(0, 255)));
        ena = 1'b0;
        for (int i = 0; i < 50; i++) cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        check("ena0_level0", 32'(level0), 32'd1);
        check("ena0_level1", 32'(level1), 32'd0);
        ena = 1'b1;
        do_reset();
        check("rst_mid_level", 32'(level0), 32'd0);
        check("rst_mid_flags", 32'({ovf0, tmo0}), 32'd0);
        sum4 = 0;
        for (int i = 0; i < 4; i++) begin
            s[i] = 8'($urandom_range(0, 255));
            sum4 += int'(s[i]);
            conv(s[i]);
        end
        check("fresh_avg", 32'(data1), 32'(sum4 / 4));

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            ena       = ($urandom_range(0, 9) != 0);
            m_ready   = ($urandom_range(0, 2) == 0);
            clr_flags = ($urandom_range(0, 29) == 0);
            cyc(($urandom_range(0, 2) != 0), 8'($urandom_range(0, 255)));
        end
        clr_flags = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
